// File: rtl/approx_add_pipe.sv
// rtl/approx_add_pipe.sv - pipelined approximate/exact unsigned adder with valid/ready flow control
module approx_add_pipe #(
  parameter int WIDTH  = 16,
  parameter int TRUNC  = 6,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_exact,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  output logic             out_exact
);

  localparam int SEG = WIDTH / STAGES;

  // Per-stage registered state, gathered so neighbouring stages can see it.
  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] carry_v;
  logic [STAGES-1:0] exact_v;
  logic [WIDTH-1:0]  sum_v [STAGES];
  logic [WIDTH-1:0]  opa_v [STAGES];
  logic [WIDTH-1:0]  opb_v [STAGES];

  // Inputs seen by each stage: the ports for stage 0, the previous stage's registers otherwise.
  logic [STAGES-1:0] v_in_w;
  logic [STAGES-1:0] c_in_w;
  logic [STAGES-1:0] ex_in_w;
  logic [WIDTH-1:0]  a_in_w [STAGES];
  logic [WIDTH-1:0]  b_in_w [STAGES];
  logic [WIDTH-1:0]  p_in_w [STAGES];

  // Advance chain: a stage moves when it is empty or its successor moves; the tail watches out_ready.
  always_comb begin
    adv = '0;
    adv[STAGES-1] = ~vld[STAGES-1] | out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      adv[k] = ~vld[k] | adv[k+1];
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = vld[STAGES-1];
  assign out_sum   = {carry_v[STAGES-1], sum_v[STAGES-1]};
  assign out_exact = exact_v[STAGES-1];

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic             valid_q;
    logic             exact_q;
    logic             carry_q;
    logic             carry_d;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_d;
    logic             c;
    logic             ci;
    logic             kill;
    logic             inj;

    if (s == 0) begin : g_head
      assign v_in_w[s]  = in_valid;
      assign c_in_w[s]  = 1'b0;
      assign ex_in_w[s] = in_exact;
      assign a_in_w[s]  = in_a;
      assign b_in_w[s]  = in_b;
      assign p_in_w[s]  = '0;
    end else begin : g_body
      assign v_in_w[s]  = vld[s-1];
      assign c_in_w[s]  = carry_v[s-1];
      assign ex_in_w[s] = exact_v[s-1];
      assign a_in_w[s]  = opa_v[s-1];
      assign b_in_w[s]  = opb_v[s-1];
      assign p_in_w[s]  = sum_v[s-1];
    end

    // Ripple this segment; below TRUNC bits are killed, at TRUNC the compensation carry is forced in.
    always_comb begin
      sum_d = p_in_w[s];
      c     = c_in_w[s];
      ci    = 1'b0;
      kill  = 1'b0;
      inj   = 1'b0;
      for (int j = 0; j < SEG; j++) begin
        kill = !ex_in_w[s] && (s * SEG + j < TRUNC);
        inj  = !ex_in_w[s] && (s * SEG + j == TRUNC);
        ci   = inj | c;
        if (kill) begin
          sum_d[s*SEG+j] = 1'b0;
          c              = 1'b0;
        end else begin
          sum_d[s*SEG+j] = a_in_w[s][s*SEG+j] ^ b_in_w[s][s*SEG+j] ^ ci;
          c = (a_in_w[s][s*SEG+j] & b_in_w[s][s*SEG+j]) |
              (ci & (a_in_w[s][s*SEG+j] ^ b_in_w[s][s*SEG+j]));
        end
      end
      carry_d = c;
    end

    // Stage register: takes the upstream beat whenever this stage advances.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        exact_q <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else if (adv[s]) begin
        valid_q <= v_in_w[s];
        if (v_in_w[s]) begin
          exact_q <= ex_in_w[s];
          carry_q <= carry_d;
          sum_q   <= sum_d;
        end
      end
    end

    assign vld[s]     = valid_q;
    assign exact_v[s] = exact_q;
    assign carry_v[s] = carry_q;
    assign sum_v[s]   = sum_q;

    if (s < STAGES - 1) begin : g_ops
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;

      // Operands ride along so later segments still see their slices.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv[s] && v_in_w[s]) begin
          a_q <= a_in_w[s];
          b_q <= b_in_w[s];
        end
      end

      assign opa_v[s] = a_q;
      assign opb_v[s] = b_q;
    end else begin : g_no_ops
      assign opa_v[s] = '0;
      assign opb_v[s] = '0;
    end
  end

endmodule

// File: tb/tb_approx_add_pipe.sv
// tb/tb_approx_add_pipe.sv - self-checking bench for approx_add_pipe
module tb_approx_add_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, in_exact;
  logic [15:0] in_a, in_b;
  logic        out_valid, out_ready, out_exact;
  logic [16:0] out_sum;

  logic        x_valid, x_ex, x_out_ready;
  logic [15:0] x_a, x_b;
  logic        x_in_ready  [4];
  logic        x_out_valid [4];
  logic        x_out_exact [4];
  logic [16:0] x_out_sum   [4];

  int checks = 0;
  int errors = 0;

  logic [17:0] mq [$];
  logic [17:0] xq [4][$];

  approx_add_pipe #(.WIDTH(16), .TRUNC(6), .STAGES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_exact(in_exact), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_exact(out_exact));

  approx_add_pipe #(.WIDTH(16), .TRUNC(0), .STAGES(1)) u_x0 (
    .clk(clk), .rst_n(rst_n), .in_valid(x_valid), .in_ready(x_in_ready[0]),
    .in_a(x_a), .in_b(x_b), .in_exact(x_ex), .out_valid(x_out_valid[0]),
    .out_ready(x_out_ready), .out_sum(x_out_sum[0]), .out_exact(x_out_exact[0]));

  approx_add_pipe #(.WIDTH(16), .TRUNC(4), .STAGES(4)) u_x1 (
    .clk(clk), .rst_n(rst_n), .in_valid(x_valid), .in_ready(x_in_ready[1]),
    .in_a(x_a), .in_b(x_b), .in_exact(x_ex), .out_valid(x_out_valid[1]),
    .out_ready(x_out_ready), .out_sum(x_out_sum[1]), .out_exact(x_out_exact[1]));

  approx_add_pipe #(.WIDTH(16), .TRUNC(8), .STAGES(16)) u_x2 (
    .clk(clk), .rst_n(rst_n), .in_valid(x_valid), .in_ready(x_in_ready[2]),
    .in_a(x_a), .in_b(x_b), .in_exact(x_ex), .out_valid(x_out_valid[2]),
    .out_ready(x_out_ready), .out_sum(x_out_sum[2]), .out_exact(x_out_exact[2]));

  approx_add_pipe #(.WIDTH(16), .TRUNC(15), .STAGES(4)) u_x3 (
    .clk(clk), .rst_n(rst_n), .in_valid(x_valid), .in_ready(x_in_ready[3]),
    .in_a(x_a), .in_b(x_b), .in_exact(x_ex), .out_valid(x_out_valid[3]),
    .out_ready(x_out_ready), .out_sum(x_out_sum[3]), .out_exact(x_out_exact[3]));

  function automatic logic [16:0] ref_sum(input logic [15:0] a, input logic [15:0] b,
                                          input logic ex, input int t);
    logic [31:0] r;
    if (ex) r = 32'(a) + 32'(b);
    else    r = ((32'(a) >> t) + (32'(b) >> t) + 32'd1) << t;
    return r[16:0];
  endfunction

  function automatic int trunc_of(input int i);
    case (i)
      0:       return 0;
      1:       return 4;
      2:       return 8;
      default: return 15;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [17:0] e;
    logic [16:0] held;
    logic [15:0] ra, rb;
    logic        rex;
    int          sent, recv;

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_exact = 1'b0; out_ready = 1'b1;
    x_valid = 1'b0; x_a = '0; x_b = '0; x_ex = 1'b0; x_out_ready = 1'b1;
    held = '0;

    #2;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_sum", out_sum, 0);
    check("reset_out_exact", out_exact, 0);
    check("reset_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // Latency-2 single beat
    in_valid = 1'b1; in_a = 16'h00FF; in_b = 16'h0001; in_exact = 1'b0;
    #1 check("t1_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("t1_lat1_valid", out_valid, 0);
    tick();
    check("t1_lat2_valid", out_valid, 1);
    check("t1_sum", out_sum, 17'h00100);
    check("t1_exact", out_exact, 0);
    tick();
    check("t1_drained", out_valid, 0);

    // All-ones, approximate then exact back to back
    in_valid = 1'b1; in_a = 16'hFFFF; in_b = 16'hFFFF; in_exact = 1'b0;
    tick();
    in_exact = 1'b1;
    tick();
    in_valid = 1'b0;
    check("t2_a_valid", out_valid, 1);
    check("t2_a_sum", out_sum, 17'h1FFC0);
    check("t2_a_exact", out_exact, 0);
    tick();
    check("t2_b_valid", out_valid, 1);
    check("t2_b_sum", out_sum, 17'h1FFFE);
    check("t2_b_exact", out_exact, 1);
    tick();
    check("t2_drained", out_valid, 0);

    // Zero operands: worst-case bias
    in_valid = 1'b1; in_a = 16'h0000; in_b = 16'h0000; in_exact = 1'b0;
    tick();
    in_exact = 1'b1;
    tick();
    in_valid = 1'b0;
    check("t3_a_sum", out_sum, 17'h00040);
    check("t3_a_valid", out_valid, 1);
    tick();
    check("t3_b_sum", out_sum, 17'h00000);
    check("t3_b_exact", out_exact, 1);
    tick();

    // Six-beat stream with downstream stalled in cycles 2..5
    sent = 0; recv = 0;
    for (int c = 0; c < 40 && recv < 6; c++) begin
      out_ready = !(c >= 2 && c <= 5);
      if (sent < 6) begin
        in_valid = 1'b1; in_a = 16'($urandom); in_b = 16'($urandom);
        in_exact = 1'($urandom_range(0, 1));
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c == 2) check("t4_in_ready_drop", in_ready, 0);
      if (c == 6) check("t4_in_ready_back", in_ready, 1);
      if (c >= 3 && c <= 5) begin
        check("t4_hold_valid", out_valid, 1);
        check("t4_hold_sum", out_sum, held);
      end
      if (c == 2) held = out_sum;
      if (in_valid && in_ready) begin
        mq.push_back({in_exact, ref_sum(in_a, in_b, in_exact, 6)});
        sent++;
      end
      if (out_valid && out_ready) begin
        if (mq.size() == 0) check("t4_underflow", 1, 0);
        else begin
          e = mq.pop_front();
          check("t4_sum", out_sum, e[16:0]);
          check("t4_exact", out_exact, e[17]);
        end
        recv++;
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("t4_received", recv, 6);

    // Asynchronous reset with two beats in flight
    in_valid = 1'b1; in_a = 16'h1234; in_b = 16'h4321; in_exact = 1'b1;
    tick();
    in_a = 16'hABCD;
    tick();
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("t5_rst_valid", out_valid, 0);
    check("t5_rst_sum", out_sum, 0);
    tick();
    #3 rst_n = 1'b1;
    ra = 16'($urandom); rb = 16'($urandom); rex = 1'($urandom_range(0, 1));
    in_valid = 1'b1; in_a = ra; in_b = rb; in_exact = rex;
    tick();
    in_valid = 1'b0;
    check("t5_lat1_valid", out_valid, 0);
    tick();
    check("t5_lat2_valid", out_valid, 1);
    check("t5_sum", out_sum, ref_sum(ra, rb, rex, 6));
    tick();
    check("t5_no_stale", out_valid, 0);

    // Random valid/ready on the default configuration
    mq.delete();
    for (int c = 0; c < 320; c++) begin
      in_valid  = (c < 300) && ($urandom_range(0, 3) != 0);
      out_ready = (c >= 300) || ($urandom_range(0, 2) != 0);
      in_a = 16'($urandom); in_b = 16'($urandom); in_exact = 1'($urandom_range(0, 1));
      #1;
      if (in_valid && in_ready) mq.push_back({in_exact, ref_sum(in_a, in_b, in_exact, 6)});
      if (out_valid && out_ready) begin
        if (mq.size() == 0) check("t6_underflow", 1, 0);
        else begin
          e = mq.pop_front();
          check("t6_sum", out_sum, e[16:0]);
          check("t6_exact", out_exact, e[17]);
        end
      end
      tick();
    end
    in_valid = 1'b0;
    check("t6_leftover", mq.size(), 0);

    // Regression across STAGES / TRUNC instances
    for (int c = 0; c < 330; c++) begin
      x_valid = (c < 300) && ($urandom_range(0, 4) != 0);
      case ($urandom_range(0, 7))
        0:       begin x_a = 16'hFFFF; x_b = 16'hFFFF; end
        1:       begin x_a = 16'h0000; x_b = 16'h0000; end
        default: begin x_a = 16'($urandom); x_b = 16'($urandom); end
      endcase
      x_ex = 1'($urandom_range(0, 1));
      #1;
      for (int i = 0; i < 4; i++) begin
        if (x_valid && x_in_ready[i]) xq[i].push_back({x_ex, ref_sum(x_a, x_b, x_ex, trunc_of(i))});
        if (x_out_valid[i]) begin
          if (xq[i].size() == 0) check("t7_underflow", 1, 0);
          else begin
            e = xq[i].pop_front();
            check($sformatf("t7_sum_inst%0d", i), x_out_sum[i], e[16:0]);
            check($sformatf("t7_exact_inst%0d", i), x_out_exact[i], e[17]);
          end
        end
      end
      tick();
    end
    x_valid = 1'b0;
    for (int i = 0; i < 4; i++) check($sformatf("t7_leftover_inst%0d", i), xq[i].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/approx_add_pipe.md
Name: approx_add_pipe

Overview:
- Parametrised, pipelined successor to the team's fixed 16-bit approximate unsigned adders.
- Adds two WIDTH-bit unsigned operands. Low TRUNC result bits are forced to zero, and a constant carry-in of 1 is injected at bit TRUNC as error compensation.
- A per-transaction mode bit selects the exact sum instead of the approximate one.
- The carry chain is cut into STAGES registered segments behind a valid/ready handshake. The block sits in FPGA datapaths where delay/accuracy trade-off is tuned per instance.

Parameters:
- WIDTH, 16, operand width in bits; result is WIDTH+1 bits.
- TRUNC, 6, number of low result bits forced to zero in approximate mode; 0 <= TRUNC < WIDTH.
- STAGES, 2, number of carry-chain segments = register levels = latency; WIDTH % STAGES == 0, 1 <= STAGES <= WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts beat this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_exact  input  1  1 = exact sum, 0 = approximate; travels with the beat.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_sum  output  WIDTH+1  result.
- out_exact  output  1  mode bit of the beat in out_sum.

Behaviour:
- Reset is asynchronous and active-low. While rst_n = 0, all stage valid flags, out_valid, out_sum, out_exact and internal carries are 0. The first capture happens on the first rising clk after rst_n deasserts.
- Reset mid-operation discards all in-flight beats; no partial result is ever presented.
- Segment width is SEG = WIDTH/STAGES. Stage s (s = 0..STAGES-1) computes result bits [s*SEG +: SEG] from the operand slices and the carry registered by stage s-1.
- Upper operand slices and the mode bit are carried forward in registers alongside the partial result.
- Carry-in to bit 0 is always 0.
- Exact mode: out_sum = in_a + in_b, full WIDTH+1 bits.
- Approximate mode:
  - bits i < TRUNC are 0 and generate no carry.
  - bit TRUNC gets carry-in 1, so sum = ~(a^b) and carry = a|b.
  - bits above TRUNC use an ordinary ripple.
  - Arithmetic equivalent: out_sum = (((in_a>>TRUNC) + (in_b>>TRUNC) + 1) << TRUNC), truncated to WIDTH+1 bits.
  - Bias bound: |error| <= 2^TRUNC.
- TRUNC boundary: TRUNC may fall inside any segment, including on a segment boundary. In that case the injected carry enters at that segment's LSB, replacing the registered carry, which is 0 there by construction.
- Latency is exactly STAGES cycles from acceptance to out_valid with no backpressure. Throughput is 1 beat/cycle.
- Handshake:
  - A beat is accepted when in_valid & in_ready.
  - A result is consumed when out_valid & out_ready.
  - Stage k advances when it is empty or stage k+1 advances; the last stage advances when out_valid = 0 or out_ready = 1.
  - in_ready = stage-0 register empty or stage 0 advancing.
  - in_ready may depend combinationally on out_ready.
- While out_valid & !out_ready, out_sum and out_exact are held stable. No beat is dropped or duplicated.
- Simultaneous accept and consume with the pipeline full is legal and keeps full throughput.
- in_exact may change every beat; results are never mixed across beats.
- Carry out of the top segment is out_sum[WIDTH]. There is no wrap-around.

Test Plan:
- WIDTH=16, TRUNC=6, STAGES=2; accept in_a=0x00FF, in_b=0x0001, in_exact=0 -> out_valid exactly 2 cycles later, out_sum=0x00100, out_exact=0.
- in_a=0xFFFF, in_b=0xFFFF: approximate -> 0x1FFC0; the same operands with in_exact=1 on the next beat -> 0x1FFFE. Results arrive back-to-back in order.
- in_a=0, in_b=0, in_exact=0 -> out_sum=0x00040 (worst-case bias 64); with in_exact=1 -> 0x00000.
- Stream 6 beats with out_ready=0 for cycles 2-5:
  - in_ready drops once both stages are full.
  - out_sum is held stable while stalled.
  - All 6 results arrive in order against the reference model, none lost.
- Assert rst_n=0 asynchronously with 2 beats in flight -> out_valid=0 and out_sum=0 before the next clk edge. After release, a new beat returns the correct sum at latency 2.
- Random regression for STAGES=1,4,16 and TRUNC=0,4,8,15 -> every result matches the arithmetic equivalent. TRUNC=0 with in_exact=0 must equal a+b+1.
